// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Purpose  : Shares one cache/memory port between the instruction-fetch    |
// |            stage and the memory stage. One transaction is outstanding at |
// |            a time; the memory command is a one-cycle pulse and the       |
// |            completion (done/data/err) is routed back to the owner.       |
// | Config   : `define MEM_ARB_FAIR_EN enables the fetch anti-starvation     |
// |            counter (STARVE_LIMIT). Without it, data has strict priority. |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            fetch side : i_req, i_addr, i_abort -> i_rdata, i_done, i_err |
// |            data side  : d_req, d_wr, d_addr, d_wdata                     |
// |                         -> d_rdata, d_done, d_err, d_wait                |
// |            memory side: mem_addr, mem_wdata, mem_rd, mem_wr (out)        |
// |                         mem_rdata, mem_done, mem_stall, mem_err (in)     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_abort,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        d_wait,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t r_state;
  logic   r_drop;         // in-flight fetch result must be discarded

  logic   w_can_grant;
  logic   w_grant_d;
  logic   w_grant_i;
  logic   w_fetch_first;  // fairness override: fetch beats data this grant
  logic   w_i_deliver;
  logic   w_d_deliver;

`ifdef MEM_ARB_FAIR_EN
  localparam int c_CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  logic [c_CNT_W-1:0] r_starve;  // consecutive data grants while fetch waited

  assign w_fetch_first = i_req && (r_starve == c_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_grant_i) begin
      r_starve <= '0;
    end else if (w_grant_d) begin
      r_starve <= i_req ? (r_starve + c_CNT_W'(1)) : '0;
    end
  end
`else
  logic w_unused_limit;

  assign w_fetch_first  = 1'b0;
  assign w_unused_limit = (STARVE_LIMIT != 0);
`endif

  assign w_can_grant = (r_state == S_IDLE) && !mem_stall;
  assign w_grant_d   = w_can_grant && d_req && !w_fetch_first;
  assign w_grant_i   = w_can_grant && i_req && !w_grant_d;

  // Completion is a combinational pass-through of the memory response,
  // gated by the owner. An abort in the completion cycle also kills it.
  assign w_i_deliver = (r_state == S_BUSY_I) && mem_done && !r_drop && !i_abort;
  assign w_d_deliver = (r_state == S_BUSY_D) && mem_done;

  assign i_done  = w_i_deliver;
  assign i_rdata = w_i_deliver ? mem_rdata : 16'h0000;
  assign i_err   = w_i_deliver && mem_err;

  assign d_done  = w_d_deliver;
  assign d_rdata = w_d_deliver ? mem_rdata : 16'h0000;
  assign d_err   = w_d_deliver && mem_err;
  // Gated by rst_n so every output reads 0 while reset is held.
  assign d_wait  = rst_n && d_req && !w_d_deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_drop    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      // Commands are single-cycle pulses.
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (w_grant_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wr    <= d_wr;
            mem_rd    <= !d_wr;
            r_state   <= S_BUSY_D;
          end else if (w_grant_i) begin
            mem_addr  <= i_addr;
            mem_wdata <= 16'h0000;
            mem_rd    <= 1'b1;
            r_state   <= S_BUSY_I;
          end
        end
        S_BUSY_I: begin
          if (mem_done) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
          end else if (i_abort) begin
            // The memory access still completes; only the result is dropped.
            r_drop <= 1'b1;
          end
        end
        S_BUSY_D: begin
          if (mem_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
